// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end: widths, default
// memory geometry and the fetch FSM state encoding.
package fetch_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam int FIFO_W = XLEN + INST_W;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam int              IMEM_WORDS_DEFAULT = 128;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO buffering fetched {pc, inst} pairs between memory and decode.
// Push while full is only accepted together with a pop; pop while empty is ignored.
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int W = FIFO_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  // Payload storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues sequential PCs to a one-cycle-latency
// instruction memory, buffers returns in a 2-entry FIFO and hands them to decode.
// Decode handshake: a word transfers in any cycle where if_valid && if_ready;
// if_inst/if_pc hold while if_valid is high and if_ready is low.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [XLEN-1:0]   if_pc,
  output logic              halted,
  output fetch_state_t      dbg_state,
  output logic [1:0]        dbg_fifo_count
);

  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_WORDS * 4);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

  logic [1:0]        fifo_count;
  logic [FIFO_W-1:0] fifo_head;
  logic              pop;
  logic              push;
  logic [2:0]        occupancy;
  logic [XLEN-1:0]   redirect_target;
  logic              pc_in_range;

  assign redirect_target = redirect_pc & ~32'h3;
  assign pc_in_range     = pc_q < PC_LIMIT;

  assign imem_addr = pc_q;
  assign if_valid  = (fifo_count != 2'd0) && !redirect_valid;
  assign pop       = if_valid && if_ready;
  assign push      = inflight_q && !redirect_valid;
  assign if_pc     = fifo_head[FIFO_W-1:INST_W];
  assign if_inst   = fifo_head[INST_W-1:0];
  assign halted    = (state_q == HALT);

  assign dbg_state      = state_q;
  assign dbg_fifo_count = fifo_count;

  // Entries the FIFO will hold once this cycle's pop and inflight return land;
  // issuing only at <=1 leaves room for the response that comes back next cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
        end else if (fetch_en && pc_in_range && (occupancy <= 3'd1)) begin
          inflight_d    = 1'b1;
          inflight_pc_d = pc_q;
          pc_d          = pc_q + 32'd4;
        end else if (!pc_in_range && !inflight_q && (fifo_count == 2'd0)) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
          if (redirect_target < PC_LIMIT) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_skid_fifo #(.W(FIFO_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({inflight_pc_q, imem_inst}),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (fifo_head),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a one-cycle-latency memory model
// holding 32'hC0DE_0000 + word index at every in-range word.
module tb_fetch_controller;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         fetch_en;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_inst;
  logic         if_valid;
  logic         if_ready;
  logic [31:0]  if_inst;
  logic [31:0]  if_pc;
  logic         halted;
  fetch_state_t dbg_state;
  logic [1:0]   dbg_fifo_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_controller dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .halted         (halted),
    .dbg_state      (dbg_state),
    .dbg_fifo_count (dbg_fifo_count)
  );

  always @(posedge clk)
    imem_inst <= (imem_addr < 32'h200) ? (32'hC0DE_0000 + (imem_addr >> 2)) : 32'hDEAD_BEEF;

  function automatic logic [31:0] model_inst(input logic [31:0] pc);
    return 32'hC0DE_0000 + (pc >> 2);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves time just after the edge that ends reset: the first post-reset cycle.
  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    fetch_en       = 1'b1;
    if_ready       = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b0) $display("FAIL reset_if_valid got %b exp 0", if_valid);
    else n_pass++;
    n_checks++;
    if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted);
    else n_pass++;
    n_checks++;
    if (imem_addr !== 32'h0) $display("FAIL reset_imem_addr got %h exp 00000000", imem_addr);
    else n_pass++;
    n_checks++;
    if (dbg_fifo_count !== 2'd0 || dbg_state !== RUN)
      $display("FAIL reset_state got count=%0d state=%0d exp 0/RUN", dbg_fifo_count, dbg_state);
    else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      n_checks++;
      if (imem_addr !== 32'(4 * c))
        $display("FAIL stream_addr c=%0d got %h exp %h", c, imem_addr, 32'(4 * c));
      else n_pass++;
      n_checks++;
      if (if_valid !== (c >= 2))
        $display("FAIL stream_valid c=%0d got %b exp %b", c, if_valid, (c >= 2));
      else n_pass++;
      if (c >= 2) begin
        n_checks++;
        if (if_pc !== 32'(4 * (c - 2)) || if_inst !== model_inst(32'(4 * (c - 2))))
          $display("FAIL stream_data c=%0d got pc=%h inst=%h exp pc=%h", c, if_pc, if_inst,
                   32'(4 * (c - 2)));
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int p = 0; p < 64; p += 4) exp_q.push_back(32'(p));
    for (int c = 0; c < 15; c++) begin
      if_ready = !(c >= 3 && c <= 7);
      @(negedge clk);
      n_checks++;
      if (if_valid !== (c >= 2))
        $display("FAIL bp_valid c=%0d got %b exp %b", c, if_valid, (c >= 2));
      else n_pass++;
      if (c >= 4 && c <= 7) begin
        n_checks++;
        if (dbg_fifo_count !== 2'd2 || imem_addr !== 32'hC)
          $display("FAIL bp_stall c=%0d got count=%0d addr=%h exp 2/0000000c", c,
                   dbg_fifo_count, imem_addr);
        else n_pass++;
        n_checks++;
        if (if_pc !== 32'h4 || if_inst !== model_inst(32'h4))
          $display("FAIL bp_hold c=%0d got pc=%h inst=%h exp pc=00000004", c, if_pc, if_inst);
        else n_pass++;
      end
      if (if_valid && if_ready && exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (if_pc !== e || if_inst !== model_inst(e))
          $display("FAIL bp_order c=%0d got pc=%h inst=%h exp pc=%h", c, if_pc, if_inst, e);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (exp_q.size() != 8) $display("FAIL bp_count got %0d left exp 8 left", exp_q.size());
    else n_pass++;
    if_ready = 1'b1;
  endtask

  task automatic test_redirect();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if_ready       = (c < 3) || (c >= 6);
      redirect_valid = (c == 5);
      redirect_pc    = (c == 5) ? 32'h13 : 32'h0;
      @(negedge clk);
      case (c)
        4: begin
          n_checks++;
          if (dbg_fifo_count !== 2'd2) $display("FAIL redir_full got %0d exp 2", dbg_fifo_count);
          else n_pass++;
        end
        5: begin
          n_checks++;
          if (if_valid !== 1'b0) $display("FAIL redir_suppress got %b exp 0", if_valid);
          else n_pass++;
        end
        6: begin
          n_checks++;
          if (dbg_fifo_count !== 2'd0 || if_valid !== 1'b0 || imem_addr !== 32'h10)
            $display("FAIL redir_flush got count=%0d valid=%b addr=%h exp 0/0/00000010",
                     dbg_fifo_count, if_valid, imem_addr);
          else n_pass++;
        end
        7: begin
          n_checks++;
          if (if_valid !== 1'b0 || imem_addr !== 32'h14)
            $display("FAIL redir_stale got valid=%b addr=%h exp 0/00000014", if_valid, imem_addr);
          else n_pass++;
        end
        8: begin
          n_checks++;
          if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_inst !== model_inst(32'h10))
            $display("FAIL redir_target got valid=%b pc=%h inst=%h exp 1/00000010",
                     if_valid, if_pc, if_inst);
          else n_pass++;
        end
        9: begin
          n_checks++;
          if (if_valid !== 1'b1 || if_pc !== 32'h14)
            $display("FAIL redir_next got valid=%b pc=%h exp 1/00000014", if_valid, if_pc);
          else n_pass++;
        end
        default: ;
      endcase
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    for (int c = 0; c < 132; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 129) begin
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'(4 * (c - 2)))
          $display("FAIL halt_stream c=%0d got valid=%b pc=%h exp 1/%h", c, if_valid, if_pc,
                   32'(4 * (c - 2)));
        else n_pass++;
      end
      if (c == 130) begin
        n_checks++;
        if (if_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 32'h200)
          $display("FAIL halt_drain got valid=%b halted=%b addr=%h exp 0/0/00000200",
                   if_valid, halted, imem_addr);
        else n_pass++;
      end
      if (c == 131) begin
        n_checks++;
        if (halted !== 1'b1 || dbg_state !== HALT)
          $display("FAIL halt_enter got halted=%b state=%0d exp 1/HALT", halted, dbg_state);
        else n_pass++;
      end
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (halted !== 1'b1 || imem_addr !== 32'h300)
      $display("FAIL halt_oor_redirect got halted=%b addr=%h exp 1/00000300", halted, imem_addr);
    else n_pass++;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (halted !== 1'b0 || imem_addr !== 32'h4)
      $display("FAIL halt_resume got halted=%b addr=%h exp 0/00000004", halted, imem_addr);
    else n_pass++;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_inst !== model_inst(32'h4))
      $display("FAIL halt_deliver got valid=%b pc=%h inst=%h exp 1/00000004", if_valid, if_pc,
               if_inst);
    else n_pass++;
  endtask

  task automatic test_fetch_en();
    do_reset();
    tick();
    fetch_en = 1'b0;
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (imem_addr !== 32'h4) $display("FAIL fen_addr c=%0d got %h exp 00000004", c, imem_addr);
      else n_pass++;
      n_checks++;
      if (if_valid !== (c == 2) || (c == 2 && if_pc !== 32'h0))
        $display("FAIL fen_drain c=%0d got valid=%b pc=%h exp %b/00000000", c, if_valid, if_pc,
                 (c == 2));
      else n_pass++;
      tick();
    end
    fetch_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if_ready = (c < 3);
      @(negedge clk);
      if (c == 4) begin
        n_checks++;
        if (dbg_fifo_count !== 2'd2 || if_valid !== 1'b1)
          $display("FAIL rst_mid_pre got count=%0d valid=%b exp 2/1", dbg_fifo_count, if_valid);
        else n_pass++;
      end
      tick();
    end
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b0 || dbg_fifo_count !== 2'd0 || imem_addr !== 32'h0 || halted !== 1'b0)
      $display("FAIL rst_mid got valid=%b count=%0d addr=%h halted=%b exp 0/0/00000000/0",
               if_valid, dbg_fifo_count, imem_addr, halted);
    else n_pass++;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0)
      $display("FAIL rst_mid_restart got valid=%b pc=%h exp 1/00000000", if_valid, if_pc);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset          = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_fetch_en();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 Parameter IMEM_WORDS, default 128: instruction memory depth in 32-bit words; legal PCs are 0 to IMEM_WORDS*4-4.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 fetch_en  in  1  permits issue of new fetches when high.
REQ-006 redirect_valid  in  1  single-cycle request to change the fetch PC (branch/jump).
REQ-007 redirect_pc  in  32  new byte PC; bits [1:0] ignored (treated as 0).
REQ-008 imem_addr  out  32  byte address to instruction memory; memory returns the word one cycle later.
REQ-009 imem_inst  in  32  registered memory output for the address presented in the previous cycle.
REQ-010 if_valid  out  1  fetched instruction available to decode.
REQ-011 if_ready  in  1  decode accepts; transfer = if_valid && if_ready.
REQ-012 if_inst  out  32  head instruction word.
REQ-013 if_pc  out  32  byte PC of if_inst.
REQ-014 halted  out  1  high while in state HALT.

Function
REQ-015 imem_addr SHALL equal pc_q (next-issue PC) combinationally every cycle.
REQ-016 Issue occurs in a cycle when state==RUN, fetch_en=1, redirect_valid=0, pc_q < IMEM_WORDS*4 and (fifo_count + inflight - pop) <= 1; issue sets inflight=1, inflight_pc=pc_q, pc_q=pc_q+4 (32-bit wrap); otherwise inflight=0.
REQ-017 When inflight=1 and redirect_valid=0, imem_inst SHALL be written with inflight_pc into a 2-entry FIFO at end of that cycle.
REQ-018 if_valid = (fifo_count != 0) && !redirect_valid; if_inst/if_pc show FIFO head; pop = if_valid && if_ready.
REQ-019 Simultaneous FIFO write and pop SHALL both take effect; FIFO SHALL never overflow and never pop when empty.
REQ-020 Latency: issue in cycle N -> if_valid with that instruction in cycle N+2 (if ahead of it is empty); sustained throughput one instruction per cycle with if_ready held high.
REQ-021 redirect_valid SHALL, in the same cycle: flush the FIFO, squash any inflight response, suppress issue and the handshake, and load pc_q = {redirect_pc[31:2],2'b00}; fetch from the new PC issues in cycle N+1.
REQ-022 States: RUN, HALT. RUN -> HALT when pc_q >= IMEM_WORDS*4, inflight=0 and fifo_count=0 (buffered instructions drain first). HALT -> RUN on redirect_valid with in-range redirect_pc; out-of-range redirect stays in HALT with pc_q updated.
REQ-023 fetch_en=0 stops issue only; inflight and buffered instructions still drain to decode.
REQ-024 if_inst/if_pc SHALL hold stable while if_valid=1 and if_ready=0.

Reset
REQ-025 On reset: pc_q=RESET_PC, inflight=0, fifo_count=0, state=RUN; hence if_valid=0, halted=0, imem_addr=RESET_PC in the first post-reset cycle.
REQ-026 Reset asserted mid-operation SHALL discard inflight and buffered instructions; reset dominates redirect_valid.

Structure
REQ-027 Shared package fetch_pkg SHALL hold RESET_PC default, IMEM_WORDS default, the fetch state enumeration (RUN, HALT) and the instruction/PC widths.
REQ-028 The 2-entry buffer SHALL be a sub-module fetch_skid_fifo (64-bit payload {pc,inst}, push/pop/flush, count output, synchronous reset).

Verification
REQ-029 Reset release, if_ready=1, memory preloaded: imem_addr 0,4,8.. on consecutive cycles; if_pc=0 at cycle 2, then one new instruction per cycle.
REQ-030 if_ready low for 5 cycles from cycle 3: fifo_count reaches 2, issue stops, if_inst/if_pc stable; on release the sequence resumes with no gap or duplicate.
REQ-031 redirect_valid with redirect_pc=32'h13 while FIFO full: FIFO empty next cycle, no stale PC delivered, imem_addr=32'h10 next cycle, if_pc=32'h10 two cycles later.
REQ-032 Straight-line run to end of memory (IMEM_WORDS=128): last if_pc=32'h1FC, then halted=1; redirect to 32'h4 -> halted=0 and if_pc=32'h4 delivered.
REQ-033 fetch_en dropped with one inflight: that instruction still delivered, no further imem issue; reset asserted with FIFO full -> if_valid=0 next cycle, imem_addr=RESET_PC.
